// File: rtl/ram_hex_display.sv
// Shows one 32-bit RAM word as two alternating 16-bit pages on four hex digits,
// the low address byte on two more, and a timed write-activity indicator.
module ram_hex_display #(
    parameter int unsigned TICK_DIV   = 25000000,
    parameter int unsigned PAGE_TICKS = 2,
    parameter int unsigned WR_TICKS   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] q,
    input  logic [15:0] address,
    input  logic        wrenable,
    input  logic        hold,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic        page,
    output logic        led_wr
);

    localparam int unsigned PW = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
    localparam int unsigned TW = (PAGE_TICKS > 1) ? $clog2(PAGE_TICKS) : 1;
    localparam int unsigned WW = (WR_TICKS > 0)   ? $clog2(WR_TICKS + 1) : 1;

    typedef enum logic {
        SHOW_LO,
        SHOW_HI
    } page_state_t;

    logic [PW-1:0] presc;
    logic          tick;
    logic [31:0]   data_r;
    logic [15:0]   addr_r;
    page_state_t   state;
    logic [TW-1:0] tcnt;
    logic          wr_prev;
    logic          wr_rise;
    logic [WW-1:0] wcnt;
    logic [15:0]   half;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign tick    = (presc == PW'(TICK_DIV - 1));
    assign wr_rise = wrenable & ~wr_prev;
    assign half    = (state == SHOW_HI) ? data_r[31:16] : data_r[15:0];

    // Prescaler free-runs regardless of hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_r <= '0;
            addr_r <= '0;
        end else if (!hold) begin
            data_r <= q;
            addr_r <= address;
        end
    end

    // Address change beats a coincident tick and restarts on the low page.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SHOW_LO;
            tcnt  <= '0;
        end else if (!hold) begin
            if (address != addr_r) begin
                state <= SHOW_LO;
                tcnt  <= '0;
            end else if (tick) begin
                if (tcnt == TW'(PAGE_TICKS - 1)) begin
                    tcnt  <= '0;
                    state <= (state == SHOW_LO) ? SHOW_HI : SHOW_LO;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_prev <= 1'b0;
            wcnt    <= '0;
            led_wr  <= 1'b0;
        end else begin
            wr_prev <= wrenable;
            if (wr_rise) begin
                led_wr <= 1'b1;
                wcnt   <= WW'(WR_TICKS);
            end else if (tick && (wcnt != '0)) begin
                wcnt <= wcnt - WW'(1);
                if (wcnt == WW'(1)) begin
                    led_wr <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hex0 <= '1;
            hex1 <= '1;
            hex2 <= '1;
            hex3 <= '1;
            hex4 <= '1;
            hex5 <= '1;
            page <= 1'b0;
        end else begin
            hex0 <= seg7(half[3:0]);
            hex1 <= seg7(half[7:4]);
            hex2 <= seg7(half[11:8]);
            hex3 <= seg7(half[15:12]);
            hex4 <= seg7(addr_r[3:0]);
            hex5 <= seg7(addr_r[7:4]);
            page <= (state == SHOW_HI);
        end
    end

endmodule
